// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, colour type and colour constants for the stream transmitter.
// The bar colour lookup is used only when VGA_TX_PATTERN_EN is defined.
package vga_timing_pkg;

    localparam int DEF_WIDTH  = 800;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_H_FP   = 40;
    localparam int DEF_H_SYNC = 48;
    localparam int DEF_H_BP   = 88;
    localparam int DEF_V_FP   = 13;
    localparam int DEF_V_SYNC = 3;
    localparam int DEF_V_BP   = 32;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COLOUR_BLACK     = 24'h000000;
    localparam rgb_t COLOUR_WHITE     = 24'hFFFFFF;
    localparam rgb_t COLOUR_YELLOW    = 24'hFFFF00;
    localparam rgb_t COLOUR_CYAN      = 24'h00FFFF;
    localparam rgb_t COLOUR_GREEN     = 24'h00FF00;
    localparam rgb_t COLOUR_MAGENTA   = 24'hFF00FF;
    localparam rgb_t COLOUR_RED       = 24'hFF0000;
    localparam rgb_t COLOUR_BLUE      = 24'h0000FF;
    localparam rgb_t COLOUR_UNDERFLOW = COLOUR_MAGENTA;

    function automatic int h_total(int width, int fp, int sync, int bp);
        return width + fp + sync + bp;
    endfunction

    function automatic int v_total(int height, int fp, int sync, int bp);
        return height + fp + sync + bp;
    endfunction

    function automatic rgb_t bar_colour(logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COLOUR_WHITE;
            3'd1:    c = COLOUR_YELLOW;
            3'd2:    c = COLOUR_CYAN;
            3'd3:    c = COLOUR_GREEN;
            3'd4:    c = COLOUR_MAGENTA;
            3'd5:    c = COLOUR_RED;
            3'd6:    c = COLOUR_BLUE;
            default: c = COLOUR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running horizontal/vertical position counters with combinational
// active-region and sync decode (sync levels are active low).
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       active,
    output logic       hs,
    output logic       vs
);

    localparam logic [9:0] H_ACT   = 10'(WIDTH);
    localparam logic [9:0] V_ACT   = 10'(HEIGHT);
    localparam logic [9:0] H_LAST  = 10'(h_total(WIDTH, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [9:0] V_LAST  = 10'(v_total(HEIGHT, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [9:0] HS_FROM = 10'(WIDTH + H_FP);
    localparam logic [9:0] HS_TO   = 10'(WIDTH + H_FP + H_SYNC);
    localparam logic [9:0] VS_FROM = 10'(HEIGHT + V_FP);
    localparam logic [9:0] VS_TO   = 10'(HEIGHT + V_FP + V_SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs     = !((hcnt >= HS_FROM) && (hcnt < HS_TO));
    assign vs     = !((vcnt >= VS_FROM) && (vcnt < VS_TO));

endmodule

// File: rtl/vga_stream_tx.sv
// Streams upstream pixels onto a registered VGA interface, substituting a marker colour on underflow.
// Define VGA_TX_PATTERN_EN to add the pattern_en input and the built-in colour-bar generator.
module vga_stream_tx
    import vga_timing_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
) (
    input  logic        VGA_CLK,
    input  logic        reset,
`ifdef VGA_TX_PATTERN_EN
    input  logic        pattern_en,
`endif
    input  logic [23:0] pix_rgb,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        clr_underflow,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_BLANK_N,
    output logic        sof,
    output logic        underflow
);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       active;
    logic       hs;
    logic       vs;

    rgb_t stream_rgb;
    rgb_t rgb_next;
    logic miss;
    logic set_uf;

    rgb_t rgb_q;
    logic hs_q;
    logic vs_q;
    logic blank_n_q;
    logic sof_q;
    logic underflow_q;

    vga_timing_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk    (VGA_CLK),
        .rst    (reset),
        .hcnt   (hcnt),
        .vcnt   (vcnt),
        .active (active),
        .hs     (hs),
        .vs     (vs)
    );

    // A missing pixel shows as the underflow colour and is not consumed.
    always_comb begin
        stream_rgb = COLOUR_BLACK;
        miss       = 1'b0;
        if (active) begin
            if (pix_valid) begin
                stream_rgb = rgb_t'(pix_rgb);
            end else begin
                stream_rgb = COLOUR_UNDERFLOW;
                miss       = 1'b1;
            end
        end
    end

`ifdef VGA_TX_PATTERN_EN
    localparam int         BAR_W    = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
    localparam logic [9:0] BAR_W_10 = 10'(BAR_W);

    logic [9:0] bar_q;
    logic [2:0] bar_idx;

    // Leftover columns when WIDTH is not a multiple of 8 stay in the last bar.
    assign bar_q     = hcnt / BAR_W_10;
    assign bar_idx   = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
    assign pix_ready = active & ~pattern_en;
    assign set_uf    = miss & ~pattern_en;
    assign rgb_next  = pattern_en ? (active ? bar_colour(bar_idx) : COLOUR_BLACK) : stream_rgb;
`else
    assign pix_ready = active;
    assign set_uf    = miss;
    assign rgb_next  = stream_rgb;
`endif

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            rgb_q     <= COLOUR_BLACK;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            sof_q     <= 1'b0;
        end else begin
            rgb_q     <= rgb_next;
            hs_q      <= hs;
            vs_q      <= vs;
            blank_n_q <= active;
            sof_q     <= (hcnt == 10'd0) && (vcnt == 10'd0);
        end
    end

    // A new miss outranks a simultaneous clear so no event is lost.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else if (set_uf) begin
            underflow_q <= 1'b1;
        end else if (clr_underflow) begin
            underflow_q <= 1'b0;
        end
    end

    assign oVGA_R       = rgb_q.r;
    assign oVGA_G       = rgb_q.g;
    assign oVGA_B       = rgb_q.b;
    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_SYNC_N  = 1'b0;
    assign oVGA_BLANK_N = blank_n_q;
    assign sof          = sof_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/vga_stream_tx.md
VGA_STREAM_TX -- requirements
Module: vga_stream_tx

Interface
- REQ-001 SHALL have parameter WIDTH, default 800: active pixels per line.
- REQ-002 SHALL have parameter HEIGHT, default 480: active lines per frame.
- REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 40/48/88: horizontal porch and sync lengths in pixels.
- REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 13/3/32: vertical porch and sync lengths in lines.
- REQ-005 SHALL have port VGA_CLK, input, 1: 25 MHz pixel clock.
- REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
- REQ-007 SHALL have port pix_rgb, input, 24: upstream pixel, {R,G,B}.
- REQ-008 SHALL have port pix_valid, input, 1: upstream pixel available.
- REQ-009 SHALL have port pix_ready, output, 1: pixel consumed this cycle when high together with pix_valid.
- REQ-010 SHALL have port clr_underflow, input, 1: clears the sticky underflow flag.
- REQ-011 SHALL have ports oVGA_R/oVGA_G/oVGA_B, output, 8 each: colour out.
- REQ-012 SHALL have ports oVGA_HS, oVGA_VS, oVGA_SYNC_N, oVGA_BLANK_N, output, 1 each: VGA control signals.
- REQ-013 SHALL have port sof, output, 1: one-cycle pulse aligned with the first active pixel of each frame.
- REQ-014 SHALL have port underflow, output, 1: sticky flag, set when an active pixel was missing.

Function
- REQ-015 SHALL keep 10-bit counters hcnt over 0..H_TOTAL-1 and vcnt over 0..V_TOTAL-1, where H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP (976) and V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP (528).
- REQ-016 SHALL increment vcnt when hcnt wraps, and SHALL wrap both counters to 0 together at (H_TOTAL-1, V_TOTAL-1).
- REQ-017 SHALL define the active region as hcnt<WIDTH and vcnt<HEIGHT.
- REQ-018 SHALL drive pix_ready combinationally equal to active.
- REQ-019 SHALL hold HS low for WIDTH+H_FP <= hcnt < WIDTH+H_FP+H_SYNC, and high otherwise.
- REQ-020 SHALL hold VS low for HEIGHT+V_FP <= vcnt < HEIGHT+V_FP+V_SYNC, and high otherwise.
- REQ-021 SHALL register all VGA outputs, giving a latency of exactly 1 cycle from counter state to pins.
- REQ-022 SHALL tie oVGA_SYNC_N to 0.
- REQ-023 SHALL drive oVGA_BLANK_N = active, delayed one cycle.
- REQ-024 SHALL output pix_rgb when active and pix_valid are both high.
- REQ-025 SHALL output the UNDERFLOW colour (FF00FF) when active is high and pix_valid is low, without consuming a pixel.
- REQ-026 SHALL output RGB 0 outside the active region, regardless of pix_valid.
- REQ-027 SHALL set underflow on any active cycle with pix_valid low, and clear it on clr_underflow; if both occur in the same cycle, set wins.
- REQ-028 SHALL assert sof in the output cycle corresponding to hcnt=0, vcnt=0.

Reset
- REQ-029 SHALL, while reset is high, force hcnt=0, vcnt=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=0, RGB=0, sof=0 and underflow=0.
- REQ-030 SHALL, on reset mid-frame, abandon the frame; after release, the first output cycle is pixel (0,0) with sof=1.

Configuration
- REQ-031 SHALL, with VGA_TX_PATTERN_EN defined, add input pattern_en (1 bit); while it is high, RGB is 8 equal-width colour bars (WIDTH/8 px each, order white, yellow, cyan, green, magenta, red, blue, black), pix_ready=0, and underflow is not set.
- REQ-032 SHALL, without VGA_TX_PATTERN_EN, omit the pattern_en port and the bar logic.

Structure
- REQ-033 SHALL place the timing defaults, H_TOTAL/V_TOTAL functions, a packed rgb_t typedef and the colour constants in package vga_timing_pkg.
- REQ-034 SHALL use one sub-module, vga_timing_counter, producing hcnt, vcnt, active, hs and vs.

Verification
- REQ-035 SHALL check: pix_valid held at 1 for one full frame -> exactly 384000 handshakes, HS low pulses of 48 cycles, 976-cycle line period, 528 lines per frame, underflow=0.
- REQ-036 SHALL check: pix_valid dropped for 1 cycle at pixel (10,5) -> output FF00FF at that position, underflow=1 and held until clr_underflow.
- REQ-037 SHALL check: clr_underflow asserted in the same cycle as a new miss -> underflow remains 1.
- REQ-038 SHALL check: reset asserted at hcnt=500, vcnt=200 -> HS=1, VS=1, BLANK_N=0 immediately; after release, sof=1 on the first output cycle.
- REQ-039 SHALL check: with VGA_TX_PATTERN_EN defined and pattern_en=1 -> pixel 0 is FFFFFF, pixel 100 is FFFF00, pix_ready=0 throughout.
